// File: rtl/quarter_sine_loader.sv
// Computes a quarter-sine table with an integer parabola, word(i) = i*(2N-i)*AMP / N^2,
// and streams it into the table RAM through a ready/valid write port.
module quarter_sine_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 12,
    parameter int AMP        = 2047
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_ready
);

    localparam int N     = 2 ** ADDR_WIDTH;
    localparam int P_W   = 2 * ADDR_WIDTH + 1;
    localparam int Q_W   = P_W + DATA_WIDTH;
    localparam int SHIFT = 2 * ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL1  = 3'd1,
        MUL2  = 3'd2,
        WRITE = 3'd3,
        FIN   = 3'd4
    } state_t;

    // p*AMP scaled back by N^2; truncation keeps the peak strictly below AMP
    function automatic logic [DATA_WIDTH-1:0] scale_to_word(input logic [P_W-1:0] p);
        return DATA_WIDTH'((Q_W'(p) * Q_W'(AMP)) >> SHIFT);
    endfunction

    state_t                state_r, state_s;
    logic [ADDR_WIDTH-1:0] idx_r, idx_s;
    logic [P_W-1:0]        p_r, p_s;
    logic                  busy_r, busy_s;
    logic                  done_r, done_s;
    logic                  wr_en_r, wr_en_s;
    logic [ADDR_WIDTH-1:0] wr_addr_r, wr_addr_s;
    logic [DATA_WIDTH-1:0] wr_data_r, wr_data_s;

    logic [P_W-1:0] idx_ext_s;
    logic [P_W-1:0] p_mul_s;

    // i*(2N-i) peaks at N^2, which needs exactly P_W bits
    assign idx_ext_s = P_W'(idx_r);
    assign p_mul_s   = idx_ext_s * (P_W'(2 * N) - idx_ext_s);

    // Next-state and next-output logic of the load sequencer
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        p_s       = p_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        wr_en_s   = wr_en_r;
        wr_addr_s = wr_addr_r;
        wr_data_s = wr_data_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = MUL1;
                    idx_s   = {ADDR_WIDTH{1'b0}};
                    busy_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            MUL1: begin
                p_s     = p_mul_s;
                state_s = MUL2;
            end
            MUL2: begin
                wr_addr_s = idx_r;
                wr_data_s = scale_to_word(p_r);
                wr_en_s   = 1'b1;
                state_s   = WRITE;
            end
            WRITE: begin
                if (wr_ready) begin
                    wr_en_s = 1'b0;
                    if (idx_r == {ADDR_WIDTH{1'b1}}) begin
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                        state_s = FIN;
                    end else begin
                        idx_s   = idx_r + ADDR_WIDTH'(1);
                        state_s = MUL1;
                    end
                end else begin
                    state_s = WRITE;
                end
            end
            FIN: begin
                done_s  = 1'b0;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
                wr_en_s = 1'b0;
            end
        endcase
    end

    // State and registered-output update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            idx_r     <= {ADDR_WIDTH{1'b0}};
            p_r       <= {P_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            wr_en_r   <= 1'b0;
            wr_addr_r <= {ADDR_WIDTH{1'b0}};
            wr_data_r <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            p_r       <= p_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            wr_en_r   <= wr_en_s;
            wr_addr_r <= wr_addr_s;
            wr_data_r <= wr_data_s;
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign wr_en   = wr_en_r;
    assign wr_addr = wr_addr_r;
    assign wr_data = wr_data_r;

endmodule

// File: tb/tb_quarter_sine_loader.sv
// Bench for quarter_sine_loader: default instance plus a small ADDR_WIDTH=4 instance,
// checked every cycle against a latency-level model of the load sequence.
module tb_quarter_sine_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0, ready0 = 1'b1;
    logic start1 = 1'b0, ready1 = 1'b1;
    logic busy0, done0, wr_en0;
    logic [7:0]  addr0;
    logic [11:0] data0;
    logic busy1, done1, wr_en1;
    logic [3:0]  addr1;
    logic [7:0]  data1;

    quarter_sine_loader dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
        .wr_en(wr_en0), .wr_addr(addr0), .wr_data(data0), .wr_ready(ready0)
    );

    quarter_sine_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .AMP(127)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .wr_en(wr_en1), .wr_addr(addr1), .wr_data(data1), .wr_ready(ready1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // model state per instance
    bit m_valid[2], m_loading[2], m_done[2], m_after_rst[2];
    int m_idx[2], m_wait[2], start_edge[2];
    // observations of the DUT write port
    int cap[2][256], wcnt[2][256], acc_cnt[2], done_cnt[2], done_edge[2], ord_err[2];
    bit prev_stall[2];
    int prev_a[2], prev_d[2];
    int golden[256];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int word(input int i, input int aw, input int amp);
        longint n;
        n = longint'(1) << aw;
        return int'((longint'(i) * (2 * n - i) * amp) >> (2 * aw));
    endfunction

    task automatic model_step(input int d, input int aw, input int amp, input logic r,
                              input logic st, input logic rdy, input logic b, input logic dn,
                              input logic we, input int a, input int dat);
        int n;
        n = 1 << aw;
        if (m_valid[d]) begin
            chk("busy", b, m_loading[d]);
            chk("done", dn, m_done[d]);
            chk("wr_en", we, m_loading[d] && m_wait[d] == 0);
            if (m_loading[d] && m_wait[d] == 0) begin
                chk("wr_addr", a, m_idx[d]);
                chk("wr_data", dat, word(m_idx[d], aw, amp));
            end
            if (m_after_rst[d]) begin
                chk("rst_addr", a, 0);
                chk("rst_data", dat, 0);
            end
            if (!r && prev_stall[d]) begin
                chk("stall_en", we, 1);
                chk("stall_addr", a, prev_a[d]);
                chk("stall_data", dat, prev_d[d]);
            end
        end
        if (m_valid[d] && !r) begin
            if (we && rdy) begin
                if (a != acc_cnt[d]) ord_err[d]++;
                cap[d][a] = dat;
                wcnt[d][a]++;
                acc_cnt[d]++;
            end
            if (dn) begin
                done_cnt[d]++;
                done_edge[d] = cyc;
            end
        end
        prev_stall[d] = !r && we && !rdy;
        prev_a[d] = a;
        prev_d[d] = dat;
        m_after_rst[d] = 1'b0;
        if (r) begin
            m_valid[d] = 1'b1; m_loading[d] = 1'b0; m_done[d] = 1'b0;
            m_idx[d] = 0; m_wait[d] = 0; m_after_rst[d] = 1'b1;
        end else if (m_loading[d]) begin
            if (m_wait[d] > 0) m_wait[d]--;
            else if (rdy) begin
                if (m_idx[d] == n - 1) begin
                    m_loading[d] = 1'b0;
                    m_done[d] = 1'b1;
                end else begin
                    m_idx[d]++;
                    m_wait[d] = 2;
                end
            end
        end else if (m_done[d]) begin
            m_done[d] = 1'b0;
        end else if (st) begin
            m_loading[d] = 1'b1; m_idx[d] = 0; m_wait[d] = 2;
            start_edge[d] = cyc + 1;
        end
    endtask

    // compare process: outputs and inputs are stable at the falling edge
    always @(negedge clk) begin
        model_step(0, 8, 2047, rst, start0, ready0, busy0, done0, wr_en0, int'(addr0), int'(data0));
        model_step(1, 4, 127, rst, start1, ready1, busy1, done1, wr_en1, int'(addr1), int'(data1));
    end

    task automatic clear_stats();
        for (int d = 0; d < 2; d++) begin
            acc_cnt[d] = 0; done_cnt[d] = 0; ord_err[d] = 0;
            for (int i = 0; i < 256; i++) begin
                wcnt[d][i] = 0; cap[d][i] = -1;
            end
        end
    endtask

    task automatic pulse_start(input bit both);
        @(posedge clk); #2;
        start0 = 1'b1; start1 = both;
        @(posedge clk); #2;
        start0 = 1'b0; start1 = 1'b0;
    endtask

    task automatic wait_done(input int d, input int target, input int limit, input string nm);
        int k;
        k = 0;
        while (done_cnt[d] < target && k < limit) begin
            @(posedge clk);
            k++;
        end
        chk({nm, "_done_timeout"}, done_cnt[d] >= target, 1);
    endtask

    function automatic int uniq(input int d, input int n);
        int u;
        u = 0;
        for (int i = 0; i < n; i++) if (wcnt[d][i] == 1) u++;
        return u;
    endfunction

    function automatic int golden_diff();
        int c;
        c = 0;
        for (int i = 0; i < 256; i++) if (cap[0][i] != golden[i]) c++;
        return c;
    endfunction

    initial begin
        int maxv, held, k;
        clear_stats();
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy0, 0);
        chk("reset_done", done0, 0);
        chk("reset_wr_en", wr_en0, 0);
        chk("reset_addr", addr0, 0);
        chk("reset_data", data0, 0);

        // unthrottled full load on both instances
        clear_stats();
        pulse_start(1'b1);
        wait_done(1, 1, 200, "A1");
        wait_done(0, 1, 1000, "A0");
        repeat (5) @(posedge clk);
        chk("A_writes", acc_cnt[0], 256);
        chk("A_unique", uniq(0, 256), 256);
        chk("A_order", ord_err[0], 0);
        chk("A_done_cnt", done_cnt[0], 1);
        chk("A_done_timing", done_edge[0] - start_edge[0], 768);
        chk("A_word0", cap[0][0], 0);
        chk("A_word1", cap[0][1], 15);
        chk("A_word128", cap[0][128], 1535);
        chk("A_word255", cap[0][255], 2046);
        maxv = 0;
        for (int i = 0; i < 256; i++) begin
            if (cap[0][i] > maxv) maxv = cap[0][i];
            golden[i] = cap[0][i];
        end
        chk("A_max_le_amp", maxv <= 2047, 1);
        chk("A_busy_after", busy0, 0);
        chk("S_writes", acc_cnt[1], 16);
        chk("S_unique", uniq(1, 16), 16);
        chk("S_word8", cap[1][8], 95);
        chk("S_word15", cap[1][15], 126);
        chk("S_done_timing", done_edge[1] - start_edge[1], 48);
        chk("S_done_cnt", done_cnt[1], 1);

        // stall at address 10, then random throttling
        clear_stats();
        pulse_start(1'b0);
        held = 0;
        for (k = 0; k < 5000 && done_cnt[0] == 0; k++) begin
            @(posedge clk); #2;
            if (wr_en0 && addr0 == 8'd10 && held < 5) begin
                ready0 = 1'b0;
                held++;
            end else begin
                ready0 = ($urandom_range(0, 3) != 0);
            end
        end
        ready0 = 1'b1;
        chk("B_done_timeout", done_cnt[0], 1);
        repeat (5) @(posedge clk);
        chk("B_stall_cycles", held, 5);
        chk("B_writes", acc_cnt[0], 256);
        chk("B_unique", uniq(0, 256), 256);
        chk("B_vs_unthrottled", golden_diff(), 0);

        // start re-pulsed mid-load is ignored
        clear_stats();
        pulse_start(1'b0);
        for (k = 0; k < 1000; k++) begin
            @(posedge clk); #2;
            if (wr_en0 && addr0 == 8'd40) break;
        end
        start0 = 1'b1;
        @(posedge clk); #2;
        start0 = 1'b0;
        wait_done(0, 1, 1000, "C");
        repeat (30) @(posedge clk);
        chk("C_writes", acc_cnt[0], 256);
        chk("C_unique", uniq(0, 256), 256);
        chk("C_order", ord_err[0], 0);
        chk("C_done_cnt", done_cnt[0], 1);
        chk("C_values", golden_diff(), 0);

        // reset while writing address 100
        clear_stats();
        pulse_start(1'b0);
        for (k = 0; k < 1000; k++) begin
            @(posedge clk); #2;
            if (wr_en0 && addr0 == 8'd100) break;
        end
        ready0 = 1'b0;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        chk("D_wr_en_after_rst", wr_en0, 0);
        chk("D_busy_after_rst", busy0, 0);
        chk("D_done_after_rst", done0, 0);
        ready0 = 1'b1;
        repeat (50) @(posedge clk);
        chk("D_partial_writes", acc_cnt[0], 100);
        chk("D_no_done", done_cnt[0], 0);
        clear_stats();
        pulse_start(1'b0);
        wait_done(0, 1, 1000, "D");
        repeat (5) @(posedge clk);
        chk("D_reload_writes", acc_cnt[0], 256);
        chk("D_reload_order", ord_err[0], 0);
        chk("D_reload_values", golden_diff(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
